// File: rtl/axi4lite_master_arbiter.sv
// axi4lite_master_arbiter: round-robin arbiter sharing one AXI4-Lite master command port between G_NB_REQ requesters
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_start/addr/rnw/strobe/wdata   flattened per-requester commands (slice i belongs to requester i)
//   req_done                   one-cycle completion pulse to the granted requester
//   req_rdata/req_access_status shared response, valid while req_done is high
//   grant_id, busy, timeout_err current/last grant, activity, sticky watchdog flag
//   start/addr/rnw/strobe/master_wdata  latched command towards the controller
//   done/master_rdata/access_status     controller response
module axi4lite_master_arbiter #(
    parameter int G_NB_REQ               = 4,
    parameter int G_AXI4_LITE_ADDR_WIDTH = 32,
    parameter int G_AXI4_LITE_DATA_WIDTH = 32,
    parameter int G_TIMEOUT              = 256
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [G_NB_REQ-1:0]                            req_start,
    input  logic [G_NB_REQ*G_AXI4_LITE_ADDR_WIDTH-1:0]     req_addr,
    input  logic [G_NB_REQ-1:0]                            req_rnw,
    input  logic [G_NB_REQ*(G_AXI4_LITE_DATA_WIDTH/8)-1:0] req_strobe,
    input  logic [G_NB_REQ*G_AXI4_LITE_DATA_WIDTH-1:0]     req_wdata,
    output logic [G_NB_REQ-1:0]                            req_done,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0]              req_rdata,
    output logic [1:0]                                     req_access_status,
    output logic [$clog2(G_NB_REQ)-1:0]                    grant_id,
    output logic                                           busy,
    output logic                                           timeout_err,
    output logic                                           start,
    output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]              addr,
    output logic                                           rnw,
    output logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]            strobe,
    output logic [G_AXI4_LITE_DATA_WIDTH-1:0]              master_wdata,
    input  logic                                           done,
    input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]              master_rdata,
    input  logic [1:0]                                     access_status
);
    localparam int AW = G_AXI4_LITE_ADDR_WIDTH;
    localparam int DW = G_AXI4_LITE_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = $clog2(G_NB_REQ);
    localparam int CW = (G_TIMEOUT > 1) ? $clog2(G_TIMEOUT) : 1;
    localparam logic [CW-1:0] TMAX = CW'((G_TIMEOUT > 0) ? G_TIMEOUT - 1 : 0);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state;
    logic [IW-1:0] last_grant, win, idx;
    logic          any_req, drain, expire;
    logic [CW-1:0] cnt;

    // Scan last_grant+1, last_grant+2, ... with wrap; the first set request wins.
    always_comb begin
        win     = last_grant;
        any_req = 1'b0;
        idx     = last_grant;
        for (int k = 0; k < G_NB_REQ; k++) begin
            idx = (idx == IW'(G_NB_REQ - 1)) ? '0 : idx + IW'(1);
            if (req_start[idx] && !any_req) begin
                win     = idx;
                any_req = 1'b1;
            end
        end
    end

    assign expire   = (G_TIMEOUT != 0) && (cnt == TMAX);
    assign busy     = state != S_IDLE;
    assign start    = state == S_ISSUE;
    assign req_done = (state == S_RESP) ? (G_NB_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            last_grant        <= IW'(G_NB_REQ - 1);
            grant_id          <= '0;
            addr              <= '0;
            rnw               <= 1'b0;
            strobe            <= '0;
            master_wdata      <= '0;
            req_rdata         <= '0;
            req_access_status <= '0;
            timeout_err       <= 1'b0;
            drain             <= 1'b0;
            cnt               <= '0;
        end else begin
            case (state)
                S_IDLE: if (any_req) begin
                    grant_id     <= win;
                    last_grant   <= win;
                    addr         <= req_addr[int'(win)*AW +: AW];
                    rnw          <= req_rnw[win];
                    strobe       <= req_strobe[int'(win)*SW +: SW];
                    master_wdata <= req_wdata[int'(win)*DW +: DW];
                    drain        <= 1'b0;
                    state        <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + CW'(1);
                    // done takes precedence over a simultaneous watchdog expiry
                    if (done) begin
                        req_rdata         <= master_rdata;
                        req_access_status <= access_status;
                        state             <= S_RESP;
                    end else if (expire) begin
                        req_rdata         <= '0;
                        req_access_status <= 2'b10;
                        timeout_err       <= 1'b1;
                        drain             <= 1'b1;
                        state             <= S_RESP;
                    end
                end
                S_RESP: state <= drain ? S_DRAIN : S_IDLE;
                // the controller still owns the late access; swallow its done before re-arbitrating
                S_DRAIN: if (done) begin
                    drain <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// tb_axi4lite_master_arbiter: self-checking bench with requester agents, controller model and response scoreboard
module tb_axi4lite_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    typedef struct {
        int            id;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [DW-1:0] rdata;
        logic [1:0]    st;
        int            dly;
        int            lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_start = '0;
    logic [N-1:0]    req_rnw = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*SW-1:0] req_strobe = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_done;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_access_status;
    logic [1:0]      grant_id;
    logic            busy, timeout_err, start, rnw;
    logic [AW-1:0]   addr;
    logic [SW-1:0]   strobe;
    logic [DW-1:0]   master_wdata;
    logic            done = 1'b0;
    logic [DW-1:0]   master_rdata = '0;
    logic [1:0]      access_status = '0;

    always #5 clk = ~clk;

    axi4lite_master_arbiter #(
        .G_NB_REQ(N), .G_AXI4_LITE_ADDR_WIDTH(AW), .G_AXI4_LITE_DATA_WIDTH(DW), .G_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_start(req_start), .req_addr(req_addr), .req_rnw(req_rnw),
        .req_strobe(req_strobe), .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata),
        .req_access_status(req_access_status), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .start(start), .addr(addr), .rnw(rnw), .strobe(strobe),
        .master_wdata(master_wdata), .done(done), .master_rdata(master_rdata),
        .access_status(access_status)
    );

    vec_t          cmdq[$], rspq[$];
    int            checks = 0, fails = 0, cyc = 0, n_start = 0, last_start = 0;
    int            start_q[$];
    int            issued[N] = '{default: 0};
    int            served[N] = '{default: 0};
    int            req_cyc[N] = '{default: 0};
    logic [N-1:0]  drop = '0;
    logic [AW-1:0] f_addr[N];
    logic [DW-1:0] f_wdata[N];
    logic [SW-1:0] f_strb[N];
    logic          f_rnw[N];
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_st = '0;
    int            m_dly = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pend_total();
        int s = 0;
        for (int i = 0; i < N; i++) s += issued[i] - served[i];
        return s;
    endfunction

    // Monitor, scoreboard and requester agents, all evaluated on the falling edge.
    initial begin
        vec_t         e;
        logic [N-1:0] jc;
        forever begin
            @(negedge clk);
            cyc++;
            if (start) begin
                if (n_start > 0) chk("start_spacing", 64'((cyc - last_start) >= 4), 1);
                n_start++;
                last_start = cyc;
                start_q.push_back(cyc);
                if (cmdq.size() == 0) chk("start_unexpected", 64'(cmdq.size()), 1);
                else begin
                    e = cmdq.pop_front();
                    chk("grant_id", 64'(grant_id), 64'(e.id));
                    chk("cmd_addr", 64'(addr), 64'(e.addr));
                    chk("cmd_rnw", 64'(rnw), 64'(e.rnw));
                    chk("cmd_strobe", 64'(strobe), 64'(e.strb));
                    chk("cmd_wdata", 64'(master_wdata), 64'(e.wdata));
                    m_rdata = e.rdata;
                    m_st    = e.st;
                    m_dly   = e.dly;
                end
            end
            if (req_done != '0) begin
                if (rspq.size() == 0) chk("done_unexpected", 64'(req_done), 0);
                else begin
                    e = rspq.pop_front();
                    chk("req_done_onehot", 64'(req_done), 64'(1) << e.id);
                    chk("req_rdata", 64'(req_rdata), 64'(e.rdata));
                    chk("req_status", 64'(req_access_status), 64'(e.st));
                    chk("resp_latency", 64'(cyc - last_start), 64'(e.lat));
                end
            end
            jc = '0;
            for (int i = 0; i < N; i++) begin
                if (req_start[i] && (req_done[i] || drop[i])) begin
                    req_start[i] = 1'b0;
                    served[i]++;
                    jc[i] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!jc[i] && !req_start[i] && !drop[i] && issued[i] > served[i]) begin
                    req_start[i]              = 1'b1;
                    req_rnw[i]                = f_rnw[i];
                    req_addr[i*AW +: AW]      = f_addr[i];
                    req_strobe[i*SW +: SW]    = f_strb[i];
                    req_wdata[i*DW +: DW]     = f_wdata[i];
                    req_cyc[i]                = cyc;
                end
            end
        end
    end

    // Controller model: answers each start after the scheduled number of cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (start) begin
                #1;
                repeat (m_dly) @(negedge clk);
                done          = 1'b1;
                master_rdata  = m_rdata;
                access_status = m_st;
                @(negedge clk);
                done          = 1'b0;
                master_rdata  = '0;
                access_status = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic issue(input vec_t c, input vec_t r, input logic has_rsp);
        f_addr[c.id]  = c.addr;
        f_wdata[c.id] = c.wdata;
        f_strb[c.id]  = c.strb;
        f_rnw[c.id]   = c.rnw;
        cmdq.push_back(c);
        if (has_rsp) rspq.push_back(r);
        issued[c.id]++;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && (cmdq.size() != 0 || rspq.size() != 0 || busy || pend_total() != 0)) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({"wait_", name}, 64'(n < budget), 1);
    endtask

    task automatic wait_start(input string name, input int n0, input int budget);
        int n = 0;
        while (n < budget && n_start == n0) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk({"start_", name}, 64'(n < budget), 1);
    endtask

    task automatic check_zero(input string t);
        chk({t, "_busy"}, 64'(busy), 0);
        chk({t, "_start"}, 64'(start), 0);
        chk({t, "_grant_id"}, 64'(grant_id), 0);
        chk({t, "_addr"}, 64'(addr), 0);
        chk({t, "_rnw"}, 64'(rnw), 0);
        chk({t, "_strobe"}, 64'(strobe), 0);
        chk({t, "_wdata"}, 64'(master_wdata), 0);
        chk({t, "_req_done"}, 64'(req_done), 0);
        chk({t, "_req_rdata"}, 64'(req_rdata), 0);
        chk({t, "_req_status"}, 64'(req_access_status), 0);
        chk({t, "_timeout_err"}, 64'(timeout_err), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v, r;
        int   n0, sz;
        tbl[0] = '{0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 2'b00, 5, 6};
        tbl[1] = '{3, 1'b1, 32'h0000_0024, 32'h0000_0000, 4'h0, 32'h1234_5678, 2'b00, 3, 4};
        tbl[2] = '{1, 1'b0, 32'h1000_0008, 32'h0BAD_F00D, 4'h3, 32'h0000_0000, 2'b11, 1, 2};
        tbl[3] = '{2, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'hA5A5_5A5A, 2'b01, 15, 16};
        tbl[4] = '{0, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 2'b00, 16, 17};
        tbl[5] = '{1, 1'b0, 32'h0000_0080, 32'h1357_9BDF, 4'h8, 32'h0000_0000, 2'b00, 2, 3};

        repeat (3) @(negedge clk);
        #2;
        check_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            n0 = n_start;
            issue(tbl[k], tbl[k], 1'b1);
            wait_idle("table", 60);
            chk("table_start_count", 64'(n_start - n0), 1);
            chk("grant_latency", 64'(start_q[start_q.size()-1] - req_cyc[tbl[k].id]), 1);
        end
        chk("no_timeout_at_boundary", 64'(timeout_err), 0);

        do_reset();
        n0 = n_start;
        v = '{0, 1'b0, 32'h0000_0100, 32'h1111_1111, 4'hF, 32'h0, 2'b00, 1, 2};
        r = '{2, 1'b1, 32'h0000_0200, 32'h0, 4'h0, 32'h2222_2222, 2'b00, 1, 2};
        issue(v, v, 1'b1);
        issue(r, r, 1'b1);
        wait_idle("simul", 60);
        chk("simul_starts", 64'(n_start - n0), 2);
        sz = start_q.size();
        chk("simul_gap", 64'(start_q[sz-1] - start_q[sz-2]), 4);

        do_reset();
        n0 = n_start;
        for (int rd = 0; rd < 3; rd++)
            for (int i = 0; i < N; i++) begin
                v = '{i, i[0], 32'h0000_0300 + 32'(i*4), 32'hF000_0000 + 32'(i), 4'(i + 1),
                      32'h5000_0000 + 32'(i), 2'(i), 2, 3};
                issue(v, v, 1'b1);
            end
        wait_idle("fair", 400);
        chk("fair_starts", 64'(n_start - n0), 12);

        n0 = n_start;
        v = '{1, 1'b1, 32'h0000_0030, 32'h0, 4'h0, 32'h0000_0BAD, 2'b00, 40, 0};
        r = '{1, 1'b1, 32'h0000_0030, 32'h0, 4'h0, 32'h0, 2'b10, 40, TO + 1};
        issue(v, r, 1'b1);
        begin
            int n = 0;
            while (n < 80 && rspq.size() != 0) begin
                @(negedge clk);
                #2;
                n++;
            end
            chk("wd_response_seen", 64'(n < 80), 1);
        end
        chk("wd_timeout_err", 64'(timeout_err), 1);
        chk("wd_busy_drain", 64'(busy), 1);
        chk("wd_no_start", 64'(start), 0);
        v = '{2, 1'b0, 32'h0000_0050, 32'h7777_8888, 4'hC, 32'h0, 2'b00, 2, 3};
        issue(v, v, 1'b1);
        wait_start("after_drain", n0 + 1, 60);
        sz = start_q.size();
        chk("drain_gap", 64'(start_q[sz-1] - start_q[sz-2]), 42);
        chk("drain_rdata_kept", 64'(req_rdata), 0);
        chk("drain_status_kept", 64'(req_access_status), 2);
        wait_idle("after_drain", 60);
        chk("timeout_sticky", 64'(timeout_err), 1);

        n0 = n_start;
        v = '{2, 1'b1, 32'h0000_0044, 32'h0, 4'h0, 32'h9999_9999, 2'b00, 10, 11};
        issue(v, v, 1'b0);
        wait_start("reset_mid", n0, 20);
        repeat (2) begin
            @(negedge clk);
            #2;
        end
        rst = 1'b1;
        drop[2] = 1'b1;
        @(negedge clk);
        #2;
        check_zero("mid_reset");
        rst = 1'b0;
        drop[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #2;
            chk("stale_done_ignored", 64'(busy), 0);
        end
        v = '{1, 1'b0, 32'h0000_0060, 32'hABCD_EF01, 4'h1, 32'h0, 2'b00, 3, 4};
        issue(v, v, 1'b1);
        wait_idle("post_reset", 60);
        chk("post_reset_latency", 64'(start_q[start_q.size()-1] - req_cyc[1]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/axi4lite_master_arbiter.md
# axi4lite_master_arbiter

Round-robin arbiter that shares one AXI4-Lite master controller command port (start/addr/rnw/strobe/master_wdata in, done/master_rdata/access_status back) between G_NB_REQ testbench requesters.
- Sits between the requesting testbench agents and the AXI4-Lite master controller; the controller keeps a single outstanding access.
- Serialises requests, latches the winning command, issues a one-cycle start, and routes the response back to the granted requester.
- Includes a response watchdog.

## Interface
- G_NB_REQ, 4, number of requesters (2..16)
- G_AXI4_LITE_ADDR_WIDTH, 32, address width
- G_AXI4_LITE_DATA_WIDTH, 32, data width; strobe width SW = G_AXI4_LITE_DATA_WIDTH/8
- G_TIMEOUT, 256, max cycles from start to done before watchdog fires; 0 disables the watchdog
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_start  in  G_NB_REQ  per-requester level request; held with its fields stable until its req_done
- req_addr  in  G_NB_REQ*ADDR  flattened; requester i uses slice [i*ADDR +: ADDR]
- req_rnw  in  G_NB_REQ  1 = read, 0 = write
- req_strobe  in  G_NB_REQ*SW  flattened write strobes
- req_wdata  in  G_NB_REQ*DATA  flattened write data
- req_done  out  G_NB_REQ  one-cycle completion pulse to the granted requester
- req_rdata  out  DATA  response read data, shared; valid while req_done is high
- req_access_status  out  2  response status, shared; valid while req_done is high
- grant_id  out  clog2(G_NB_REQ)  index of the current or last granted requester
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set when the watchdog fires, cleared only by rst
- start  out  1  one-cycle pulse to the controller
- addr  out  ADDR  latched command to the controller
- rnw  out  1  latched command to the controller
- strobe  out  SW  latched command to the controller
- master_wdata  out  DATA  latched command to the controller
- done  in  1  controller completion pulse
- master_rdata  in  DATA  controller read data, valid with done
- access_status  in  2  controller access status, valid with done

## Operation

**Reset**
- FSM goes to IDLE; last_grant = G_NB_REQ-1, so requester 0 has first priority.
- Every output is 0, including grant_id, timeout_err and all latched command registers.

**IDLE**
- If any req_start bit is set, pick the first set bit scanning last_grant+1, last_grant+2, … with wrap modulo G_NB_REQ.
- Latch that requester's addr/rnw/strobe/wdata slices into the command registers; set grant_id and last_grant; go to ISSUE.

**ISSUE**
- start = 1 for exactly this cycle; clear the wait counter; go to WAIT.

**WAIT**
- The counter increments each cycle.
- On done: register master_rdata and access_status into req_rdata and req_access_status; go to RESP.
- If G_TIMEOUT ≠ 0 and the counter reaches G_TIMEOUT-1 without done:
  - set req_access_status = 2'b10 (SLVERR) and req_rdata = 0;
  - set timeout_err;
  - go to RESP with the drain flag set.

**RESP**
- req_done[grant_id] = 1 for one cycle.
- Go to DRAIN if the drain flag is set, otherwise go to IDLE.

**DRAIN**
- Wait for done and discard its data, then go to IDLE.
- No new start is issued while the controller is still busy.

**Other rules**
- Command registers are stable from ISSUE until the next grant; requester inputs are ignored outside IDLE.
- Non-granted requests stay pending and are never dropped.
- A requester must deassert req_start in the cycle after its req_done pulse, otherwise it is re-arbitrated as a new request.

## Timing
- Request sampled in IDLE at cycle T → start high at T+1 (grant latency of 1 cycle).
- done at cycle D → req_done high at D+1 → IDLE at D+2.
- Minimum spacing between successive start pulses is 4 cycles.
- A done pulse at the same cycle as the watchdog expiry wins: the normal response is returned and timeout_err is not set.
- A done pulse arriving while in ISSUE, IDLE or RESP is ignored; only WAIT and DRAIN consume done.
- rst asserted in any state, including WAIT or DRAIN, returns to the reset state on the next edge. An in-flight controller access is abandoned and its eventual done is ignored in IDLE.
- Round-robin rotation guarantees that any held request is granted within G_NB_REQ arbitration rounds.

## Test plan
- **Single write.** Req0 requests write, addr=0x10, wdata=0xDEADBEEF, strobe=0xF; controller model returns done 5 cycles after start → start pulses once with those fields; req_done[0] pulses one cycle after done, status 2'b00; grant_id=0.
- **Simultaneous requests.** Req0 and req2 request in the same cycle after reset → req0 served first, then req2; exactly two start pulses, ≥4 cycles apart.
- **Fairness.** All 4 requesters hold requests continuously for 12 accesses → grant order is 0,1,2,3,0,1,2,3,… with no starvation.
- **Read routing.** Req3 reads addr=0x24; model returns master_rdata=0x12345678, status 2'b00 → req_rdata=0x12345678 valid only while req_done[3] is high; req_done[0..2] stay 0.
- **Watchdog.** G_TIMEOUT=16; model never answers for 40 cycles → req_done pulses with status 2'b10 at start+17 and timeout_err sets; a late done at cycle 40 is drained; next request issues start only after that.
- **Reset mid-transfer.** rst in WAIT → all outputs 0 next cycle, state IDLE, last_grant reset so a new req1-only request is granted immediately; a stale done is ignored.
